// File: rtl/scroll_addr_gen.sv
// Framebuffer address generator with 2-D wrap-around scroll.
// Maps VGA scan coordinates to a downscaled image address.
module scroll_addr_gen #(
  parameter int unsigned IMG_W       = 320,
  parameter int unsigned IMG_H       = 240,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned FRAME_DIV   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              frame_tick,
  input  logic              toggle_pulse,
  input  logic              clr_pulse,
  input  logic [1:0]        dir,
  input  logic [3:0]        step,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              running,
  output logic [8:0]        x_off,
  output logic [8:0]        y_off
);

  localparam int unsigned DIV_W =
    (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(FRAME_DIV - 1);
  localparam logic [9:0]  W10 = 10'(IMG_W);
  localparam logic [9:0]  H10 = 10'(IMG_H);
  localparam logic [10:0] W11 = 11'(IMG_W);
  localparam logic [10:0] H11 = 11'(IMG_H);

  typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [8:0]        x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              step_evt;
  logic [9:0]        step10, xs, ys;
  logic [9:0]        sx, sy;
  logic [10:0]       px, py;

  assign step10 = {6'd0, step};

  // Run/pause FSM, divider and scroll offset next-state logic.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    x_d      = x_q;
    y_d      = y_q;
    step_evt = 1'b0;
    xs       = {1'b0, x_q};
    ys       = {1'b0, y_q};
    if (toggle_pulse) begin
      state_d = (state_q == RUN) ? PAUSE : RUN;
    end
    if (clr_pulse) begin
      div_d = '0;
      x_d   = '0;
      y_d   = '0;
    end else if (state_q == RUN && frame_tick) begin
      if (div_q == DIV_MAX) begin
        div_d    = '0;
        step_evt = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
    if (step_evt) begin
      unique case (dir)
        2'd0: begin
          ys = {1'b0, y_q} + step10;
          if (ys >= H10) ys = ys - H10;
          y_d = ys[8:0];
        end
        2'd1: begin
          if ({1'b0, y_q} >= step10) ys = {1'b0, y_q} - step10;
          else ys = {1'b0, y_q} + H10 - step10;
          y_d = ys[8:0];
        end
        2'd2: begin
          xs = {1'b0, x_q} + step10;
          if (xs >= W10) xs = xs - W10;
          x_d = xs[8:0];
        end
        default: begin
          if ({1'b0, x_q} >= step10) xs = {1'b0, x_q} - step10;
          else xs = {1'b0, x_q} + W10 - step10;
          x_d = xs[8:0];
        end
      endcase
    end
  end

  // Downscale scan position, add scroll offset with wrap, linearise.
  always_comb begin
    sx = h_cnt >> SCALE_SHIFT;
    sy = v_cnt >> SCALE_SHIFT;
    px = {1'b0, sx} + {2'b0, x_q};
    py = {1'b0, sy} + {2'b0, y_q};
    if (px >= W11) px = px - W11;
    if (py >= H11) py = py - H11;
    if (sx < W10 && sy < H10) begin
      addr_d = ADDR_W'(py) * ADDR_W'(IMG_W) + ADDR_W'(px);
    end else begin
      addr_d = '0;
    end
  end

  // State, divider, offset and address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PAUSE;
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
    end
  end

  assign pixel_addr = addr_q;
  assign running    = (state_q == RUN);
  assign x_off      = x_q;
  assign y_off      = y_q;

endmodule

// File: doc/scroll_addr_gen.md
Name: scroll_addr_gen

Overview:
- Parametrised framebuffer address generator for the VGA path. It sits between vga_controller (h_cnt/v_cnt) and the block-RAM image store.
- Maps 640x480 scan coordinates to a downscaled IMG_W x IMG_H image address, with a 2-D wrap-around scroll offset.
- Scroll supports four selectable directions and a programmable step size. A frame-rate divider sets scroll speed.
- A run/pause FSM is toggled by a one-pulse input, and an offset-clear control returns the image to origin.

Parameters:
- IMG_W, 320, image width in pixels
- IMG_H, 240, image height in pixels
- SCALE_SHIFT, 1, log2 of the screen-to-image downscale factor (1 gives 640->320)
- ADDR_W, 17, pixel_addr width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- FRAME_DIV, 1, number of frame_tick pulses per scroll step (>=1)

Ports:
- clk, input, 1, system clock
- rst, input, 1, asynchronous active-high reset
- h_cnt, input, 10, current horizontal scan position
- v_cnt, input, 10, current vertical scan position
- frame_tick, input, 1, one-cycle pulse per frame, driven at vsync start
- toggle_pulse, input, 1, one-cycle pulse that toggles run/pause
- clr_pulse, input, 1, one-cycle pulse that zeroes both offsets
- dir, input, 2, scroll direction: 0=up, 1=down, 2=left, 3=right
- step, input, 4, pixels moved per scroll event (1..15; 0 means no motion)
- pixel_addr, output, ADDR_W, registered image address
- running, output, 1, 1 when the FSM is in RUN
- x_off, output, 9, current horizontal offset, range 0..IMG_W-1
- y_off, output, 9, current vertical offset, range 0..IMG_H-1

Behaviour:
- Reset (async, rst=1): running=0 (PAUSE state), x_off=0, y_off=0, frame divider count=0, pixel_addr=0.
- FSM states: PAUSE and RUN.
  - toggle_pulse=1 flips the state on the next clk edge.
  - running mirrors the state register.
- Frame divider:
  - Increments only on a frame_tick that arrives while in RUN.
  - On reaching FRAME_DIV-1 it wraps to 0 and generates an internal step_evt in the same cycle.
  - The count is frozen while in PAUSE.
- Scroll update on step_evt, using the dir and step values sampled in that cycle:
  - up: y_off = (y_off + step) mod IMG_H
  - down: y_off = (y_off - step) mod IMG_H
  - left: x_off = (x_off + step) mod IMG_W
  - right: x_off = (x_off - step) mod IMG_W
  - Modulo is implemented as one conditional add or subtract of IMG_W/IMG_H. This is valid because step < IMG_W and step < IMG_H is a requirement.
- Offsets change only on step_evt, so there is no mid-frame tearing provided frame_tick is driven at vsync.
- Priority within a cycle:
  - clr_pulse is highest. It zeroes x_off, y_off and the divider count, and step_evt is suppressed that cycle. clr_pulse does not change the FSM state.
- Simultaneous toggle_pulse and frame_tick:
  - The divider and step_evt are evaluated against the pre-toggle state.
  - A RUN->PAUSE toggle still applies that cycle's step.
  - A PAUSE->RUN toggle does not count that tick.
- Address path:
  - sx = h_cnt >> SCALE_SHIFT, sy = v_cnt >> SCALE_SHIFT
  - px = (sx + x_off) mod IMG_W, py = (sy + y_off) mod IMG_H
  - pixel_addr = py*IMG_W + px, registered; latency is 1 clk from h_cnt/v_cnt.
  - If sx >= IMG_W or sy >= IMG_H (blanking or out-of-image), pixel_addr = 0.
- All arithmetic is unsigned and wide enough to hold IMG_W*IMG_H-1 without overflow.
- dir and step changes take effect only at the next step_evt and do not alter the current offset.
- Reset asserted mid-operation returns everything to reset values immediately, with no pending state retained.

Test Plan:
- Reset, then h_cnt=10, v_cnt=4 held -> one clk later pixel_addr = 2*320+5 = 645; running=0; offsets 0.
- toggle_pulse, dir=2, step=3, 4 frame_ticks (FRAME_DIV=1) -> x_off=12. With h_cnt=630, v_cnt=0: sx=315, px=(315+12)-320=7, so pixel_addr=7.
- From x_off=0, dir=3, step=5, 1 tick -> x_off=315. Then dir=1, step=7 from y_off=0, 1 tick -> y_off=233.
- FRAME_DIV=4, RUN, dir=0, step=2, 10 ticks -> y_off=4 (2 events). Pause, 5 more ticks -> y_off unchanged at 4. Resume, 2 ticks -> y_off=6.
- clr_pulse asserted in the same cycle as a step_evt frame_tick -> x_off=y_off=0 next cycle, divider=0, running unchanged.
- h_cnt=640 or v_cnt=480, or toggle_pulse coincident with frame_tick in RUN (step applied, running=0) -> pixel_addr=0 for out-of-range; async rst mid-scroll clears all outputs without waiting for a clk edge.
